// File: rtl/lora_alarm_frame_decoder_if.sv
// Byte-stream interface between uart_rx and the LoRa alarm frame decoder.
//
// Handshake: rx_valid is a one-cycle strobe, one per received byte; rx_data
// is meaningful only in a cycle where rx_valid is high. There is no
// back-pressure, so the receiver must accept every strobed byte.
//
// Signals:
//   rx_data  [7:0]  received byte
//   rx_valid        byte strobe
// Modports:
//   master  byte source (uart_rx side)
//   slave   byte sink (decoder side)
interface lora_alarm_frame_decoder_if;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (output rx_data, output rx_valid);
    modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/lora_alarm_frame_decoder.sv
// LoRa alarm frame decoder.
//
// Parses 4-byte alarm frames HEAD, ID, CODE, CHK (CHK = ID + CODE mod 256)
// from the UART byte stream. An accepted frame with code 1..N_EVT sets a
// sticky per-event flag. Code 0 is a remote cancel that clears every flag.
// Bad ID, bad checksum, out-of-range code and inter-byte timeout all
// produce a frame_err strobe, and the number of strobes is kept in a
// saturating counter.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   rx         byte stream (slave modport): rx_data, rx_valid
//   clr_evt    per-bit flag clear, level-sampled every cycle
//   evt_flags  sticky flags; bit k = code k+1 received
//   evt_code   code of the last accepted event frame
//   evt_pulse  one-cycle strobe per accepted event frame
//   frame_err  one-cycle strobe per rejected/timed-out frame
//   err_cnt    saturating count of frame_err strobes
//   state_dbg  current parser state (0 IDLE, 1 S_ID, 2 S_CODE, 3 S_CHK)
module lora_alarm_frame_decoder #(
    parameter int         N_EVT       = 3,
    parameter logic [7:0] HEAD        = 8'hAA,
    parameter logic [7:0] DEV_ID      = 8'h31,
    parameter int         TIMEOUT_CYC = 2500000,
    parameter int         ERR_W       = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    lora_alarm_frame_decoder_if.slave rx,
    input  logic [N_EVT-1:0]          clr_evt,
    output logic [N_EVT-1:0]          evt_flags,
    output logic [7:0]                evt_code,
    output logic                      evt_pulse,
    output logic                      frame_err,
    output logic [ERR_W-1:0]          err_cnt,
    output logic [1:0]                state_dbg
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] S_ID   = 2'd1;
    localparam logic [1:0] S_CODE = 2'd2;
    localparam logic [1:0] S_CHK  = 2'd3;

    localparam int             CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [1:0]       state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [7:0]       code_q, code_n;
    logic [7:0]       chk_exp;
    logic [N_EVT-1:0] code_onehot;
    logic [N_EVT-1:0] set_mask;
    logic             code_in_range;
    logic             cancel;
    logic             accept;
    logic             ferr_n;

    assign state_dbg     = state_q;
    assign chk_exp       = DEV_ID + code_q;
    assign code_in_range = (code_q != 8'd0) && (int'(code_q) <= N_EVT);

    always_comb begin
        code_onehot = '0;
        for (int k = 0; k < N_EVT; k++) begin
            code_onehot[k] = (code_q == 8'(k + 1));
        end
    end

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        code_n   = code_q;
        set_mask = '0;
        cancel   = 1'b0;
        accept   = 1'b0;
        ferr_n   = 1'b0;

        if (rx.rx_valid) begin
            // A byte always restarts the inter-byte timer, even in the
            // cycle the timer would otherwise expire.
            cnt_n = '0;
            case (state_q)
                IDLE: begin
                    if (rx.rx_data == HEAD) state_n = S_ID;
                end
                S_ID: begin
                    // DEV_ID is checked first so a HEAD==DEV_ID build still
                    // advances instead of resyncing forever.
                    if (rx.rx_data == DEV_ID) begin
                        state_n = S_CODE;
                    end else if (rx.rx_data == HEAD) begin
                        state_n = S_ID;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
                S_CODE: begin
                    code_n  = rx.rx_data;
                    state_n = S_CHK;
                end
                S_CHK: begin
                    state_n = IDLE;
                    if (rx.rx_data != chk_exp) begin
                        ferr_n = 1'b1;
                    end else if (code_q == 8'd0) begin
                        cancel = 1'b1;
                        accept = 1'b1;
                    end else if (code_in_range) begin
                        set_mask = code_onehot;
                        accept   = 1'b1;
                    end else begin
                        ferr_n = 1'b1;
                    end
                end
            endcase
        end else if (state_q != IDLE) begin
            if (cnt_q == CNT_LAST) begin
                state_n = IDLE;
                cnt_n   = '0;
                ferr_n  = 1'b1;
            end else begin
                cnt_n = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            code_q    <= '0;
            evt_flags <= '0;
            evt_code  <= '0;
            evt_pulse <= 1'b0;
            frame_err <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            code_q    <= code_n;
            evt_pulse <= accept;
            frame_err <= ferr_n;
            // Clear first, then set, so a same-cycle set on a bit wins;
            // a cancel overrides both.
            if (cancel) begin
                evt_flags <= '0;
            end else begin
                evt_flags <= (evt_flags & ~clr_evt) | set_mask;
            end
            // code_q is 0 on a cancel, so one assignment covers both cases.
            if (accept) evt_code <= code_q;
            if (ferr_n && (err_cnt != {ERR_W{1'b1}})) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/lora_alarm_frame_decoder.md
Name: lora_alarm_frame_decoder

Overview:
- Parametrised successor to the single-byte LoRa alarm decoder.
- Takes the UART receive byte stream from the LoRa module and parses framed alarm messages (header, device ID, event code, checksum).
- Keeps one sticky flag per event type (smoke, vibration, doorbell, …), each clearable individually. Also reports the last event code, a one-cycle event strobe, frame errors and an inter-byte timeout.
- Sits between uart_rx and the voice/display alarm logic on the in-home board.

Parameters:
- N_EVT, 3, number of event types; valid codes are 1..N_EVT (1 smoke, 2 vibration, 3 doorbell); range 1..254.
- HEAD, 8'hAA, frame header byte.
- DEV_ID, 8'h31, device ID this board accepts.
- TIMEOUT_CYC, 2500000, idle clk cycles allowed between bytes inside a frame; must be ≥2.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  received byte, valid only with rx_valid
- rx_valid  in  1  one-cycle strobe, one per received byte
- clr_evt  in  N_EVT  per-bit clear of evt_flags, level-sampled each cycle
- evt_flags  out  N_EVT  sticky flags; bit k = code k+1 received
- evt_code  out  8  code of the last accepted event frame
- evt_pulse  out  1  one-cycle strobe on each accepted event frame
- frame_err  out  1  one-cycle strobe on checksum, ID, code or timeout error
- err_cnt  out  ERR_W  saturating count of frame_err strobes

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE; timeout counter clears.
  - evt_flags, evt_code, err_cnt go to 0; evt_pulse and frame_err go to 0.
  - Reset mid-frame discards the partial frame; no error is reported.
- Frame format: HEAD, ID, CODE, CHK, where CHK = (ID + CODE) mod 256.
- State machine: IDLE → S_ID → S_CODE → S_CHK. Each transition happens only on rx_valid.
  - IDLE: byte==HEAD → S_ID. Any other byte is ignored silently.
  - S_ID: byte==DEV_ID → S_CODE.
    - Byte==HEAD (and HEAD≠DEV_ID) → stay in S_ID (resync, no error).
    - Any other byte → frame_err, go to IDLE.
  - S_CODE: latch the byte as code → S_CHK.
  - S_CHK: compare byte with (DEV_ID + code) mod 256, then go to IDLE.
    - Mismatch → frame_err.
    - Match, code in 1..N_EVT → set evt_flags[code-1], evt_code←code, evt_pulse.
    - Match, code==0 → clear all evt_flags, evt_code←0, evt_pulse (remote cancel).
    - Match, code>N_EVT → frame_err; flags unchanged.
- Latency: evt_flags, evt_code, evt_pulse and frame_err update on the clk edge that samples the CHK-byte rx_valid, so they are visible 1 cycle after the strobe. Each pulse is exactly 1 cycle wide.
- Timeout:
  - In any state other than IDLE, a counter increments on every cycle without rx_valid and resets on rx_valid.
  - When the counter reaches TIMEOUT_CYC-1: state goes to IDLE, frame_err pulses, counter clears.
  - In IDLE the counter holds at 0.
  - If rx_valid arrives in the same cycle the count would expire, the byte wins and there is no timeout.
- Clear:
  - Bits set in clr_evt clear the matching flags each cycle.
  - If a set and a clear hit the same bit in the same cycle, set wins.
  - A code-0 cancel and clr_evt together give all zeros.
  - clr_evt does not affect evt_code.
- err_cnt increments on each frame_err pulse and saturates at 2^ERR_W-1; it never wraps.
- Only one frame is in flight at a time; bytes arriving while a frame is in progress are always consumed by the state machine.

Test Plan:
- Bytes AA 31 02 33 → 1 cycle after the last strobe: evt_flags=3'b010, evt_code=8'h02, evt_pulse high for exactly 1 cycle, frame_err=0, err_cnt=0.
- AA 31 01 33 (bad checksum) → frame_err for 1 cycle, err_cnt=1, evt_flags unchanged, evt_pulse never asserted.
- AA 31 then no byte for TIMEOUT_CYC cycles (bench TIMEOUT_CYC=16) → frame_err at cycle 16 after the ID byte, state back in IDLE. A following AA 31 03 34 → evt_flags bit2 set.
- Resync and out-of-range code: AA AA 31 01 32 → evt_flags bit0 set, no error. Then AA 31 07 38 → frame_err, err_cnt+1, flags unchanged.
- Flags 3'b111 set, then clr_evt=3'b010 held 1 cycle → flags 3'b101. Then frame AA 31 02 33 whose update edge coincides with clr_evt=3'b010 → flags 3'b111 (set wins). Then AA 31 00 31 → flags 3'b000, evt_code=0, evt_pulse.
- rst asserted after AA 31 02 → all outputs 0, no frame_err. After release, 02 33 alone → no event. Separately, 300 bad frames with ERR_W=8 → err_cnt=255.
